audio_stream_ctrl: RTL and testbench
====================================

AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 Parameter WAKE_CYCLES, 15360, clk cycles for microphone wake-up (10 ms at 1.536 MHz); SHALL be >= 1.
REQ-002 Parameter SETTLE_SAMPLES, 32, filtered samples discarded while the decimation chain settles; SHALL be >= 1.
REQ-003 Parameter DEPTH, 8, output FIFO entries; SHALL be a power of two, >= 2.
REQ-004 clk  in  1  single system clock (1.536 MHz, same clock driven to the microphone).
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  level; 1 = run capture, 0 = stop and flush.
REQ-007 sample_in  in  16  signed PCM sample from the FIR stage.
REQ-008 sample_valid  in  1  one-cycle strobe qualifying sample_in.
REQ-009 rd_pulse  in  1  one-cycle pop request from the SPI block, already in the clk domain.
REQ-010 sample_out  out  16  FIFO head sample; 16'h0000 when the FIFO is empty.
REQ-011 data_ready  out  1  FIFO non-empty and state STREAM.
REQ-012 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  out  1  sticky; a sample was dropped because the FIFO was full.
REQ-014 state_out  out  2  current state encoding.

Function
REQ-015 States: IDLE=0, WAKE=1, SETTLE=2, STREAM=3. All state changes SHALL be registered.
REQ-016 IDLE to WAKE SHALL occur on the first clk edge with enable=1. The same edge SHALL clear overflow and the wake counter.
REQ-017 WAKE SHALL count clk cycles and go to SETTLE after exactly WAKE_CYCLES cycles. sample_valid SHALL be ignored in WAKE.
REQ-018 SETTLE SHALL discard sample_valid strobes. After the SETTLE_SAMPLES-th discarded strobe it SHALL go to STREAM on the next edge; that strobe SHALL NOT be written.
REQ-019 In STREAM, each sample_valid SHALL push sample_in. The sample SHALL appear on sample_out/data_ready on the following cycle if the FIFO was empty (latency 1).
REQ-020 rd_pulse with the FIFO non-empty SHALL pop the head. rd_pulse with the FIFO empty SHALL be ignored and SHALL have no side effects.
REQ-021 Push to a full FIFO without a simultaneous pop SHALL drop sample_in, set overflow and leave contents unchanged.
REQ-022 Simultaneous push and pop SHALL both take effect with fifo_level unchanged. This includes the full case, where overflow SHALL NOT be set.
REQ-023 enable=0 in any non-IDLE state SHALL go to IDLE on the next edge, flush the FIFO (fifo_level=0) and clear the counters. overflow SHALL be retained.
REQ-024 data_ready SHALL be 0 outside STREAM.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH. fifo_level SHALL range over 0..DEPTH.

Reset
REQ-026 reset_n=0 SHALL immediately force: state IDLE, FIFO empty, all counters 0, sample_out=0, data_ready=0, fifo_level=0, overflow=0, state_out=0, and peak_out=0 if present.
REQ-027 Reset asserted mid-operation SHALL abandon the FIFO contents. After release the block SHALL restart at IDLE, with no output glitch in the cycle of release.

Configuration
REQ-028 Macro AUDIO_STREAM_PEAK_EN defined: add output peak_out [15:0]. peak_out SHALL hold the maximum |sample| of samples pushed in STREAM. |-32768| SHALL saturate to 32767. peak_out SHALL clear on entering STREAM and update one cycle after each push.
REQ-029 Macro AUDIO_STREAM_PEAK_EN undefined: the peak_out port and its logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-030 Shared package audio_pkg SHALL hold: sample_t (signed 16-bit), the stream_state_t enum (IDLE/WAKE/SETTLE/STREAM), and the default constants for WAKE_CYCLES, SETTLE_SAMPLES and DEPTH.
REQ-031 FIFO storage and pointers SHALL live in one sub-module, sample_fifo, parameterised by DEPTH. The controller FSM, counters and peak logic SHALL remain in audio_stream_ctrl.

Verification (WAKE_CYCLES=20, SETTLE_SAMPLES=4, DEPTH=4 for the bench)
REQ-032 Startup: raise enable, strobe samples 1..10 every 8 cycles. Required: state_out=1 for exactly 20 cycles, then 2. The first 4 strobes after WAKE are dropped. FIFO receives 5,6,..., and sample_out=5 one cycle after its strobe.
REQ-033 Overflow: in STREAM push 0x0101..0x0105 with no pops. Required: fifo_level=4, overflow=1, and pops return 0x0101..0x0104.
REQ-034 Full with simultaneous push+pop: fill to 4, then push 0x7FFF and rd_pulse in the same cycle. Required: fifo_level stays 4, overflow=0, and the last pop returns 0x7FFF.
REQ-035 Stop/flush: 3 entries queued, drop enable. Required next cycle: state_out=0, fifo_level=0, data_ready=0, sample_out=0. Re-enable: overflow clears.
REQ-036 Reset mid-STREAM: 2 entries queued, pulse reset_n low for 3 cycles. Required: all outputs 0 immediately, state IDLE after release, and a full WAKE sequence on the next enable.
REQ-037 (AUDIO_STREAM_PEAK_EN) Push -5, 300, -32768, 12. Required: peak_out=5, 300, 32767, 32767.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and default sizing for the microphone capture path.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAKE   = 2'd1,
        SETTLE = 2'd2,
        STREAM = 2'd3
    } stream_state_t;

    localparam int WAKE_CYCLES_DEF    = 15360;
    localparam int SETTLE_SAMPLES_DEF = 32;
    localparam int DEPTH_DEF          = 8;

    // Magnitude with -32768 clamped so the result always fits 15 bits.
    function automatic logic [15:0] sat_abs(input sample_t s);
        logic [15:0] r;
        if (s == 16'sh8000)
            r = 16'h7FFF;
        else if (s[15])
            r = 16'(-s);
        else
            r = 16'(s);
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO: circular buffer with power-of-two depth and synchronous flush.
// Latency: a write into an empty FIFO is visible on o_head_dat the next cycle.
// Backpressure: a write while full is taken only if a pop happens in the same cycle.
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  sample_t                  i_wr_dat,
    output sample_t                  o_head_dat,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    sample_t       r_mem [DEPTH];

    logic w_do_pop;
    logic w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush)
            r_mem[r_wr_ptr] <= i_wr_dat;
    end

    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level    = r_count;

endmodule

// File: rtl/audio_stream_ctrl.sv
// Microphone capture controller: wake, settle, then stream samples into a FIFO (AUDIO_STREAM_PEAK_EN adds peak_out).
// Latency: a sample pushed into an empty FIFO appears on sample_out/data_ready one cycle later.
// Backpressure: none upstream; pushes to a full FIFO without a pop are dropped and flag overflow.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int WAKE_CYCLES    = WAKE_CYCLES_DEF,
    parameter int SETTLE_SAMPLES = SETTLE_SAMPLES_DEF,
    parameter int DEPTH          = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [15:0]              sample_in,
    input  logic                     sample_valid,
    input  logic                     rd_pulse,
    output logic [15:0]              sample_out,
    output logic                     data_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
`ifdef AUDIO_STREAM_PEAK_EN
    output logic [15:0]              peak_out,
`endif
    output logic [1:0]               state_out
);

    localparam int WCW = $clog2(WAKE_CYCLES + 1);
    localparam int SCW = $clog2(SETTLE_SAMPLES + 1);

    stream_state_t r_state;
    stream_state_t w_next;

    logic [WCW-1:0] r_wake_cnt;
    logic [SCW-1:0] r_settle_cnt;
    logic           r_overflow;

    logic                   w_wake_done;
    logic                   w_settle_done;
    logic                   w_flush;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_accept;
    logic                   w_empty;
    logic                   w_full;
    sample_t                w_head;
    logic [$clog2(DEPTH):0] w_level;

    assign w_wake_done   = (r_wake_cnt == WCW'(WAKE_CYCLES - 1));
    assign w_settle_done = sample_valid && (r_settle_cnt == SCW'(SETTLE_SAMPLES - 1));
    assign w_pop         = rd_pulse && !w_empty;
    assign w_accept      = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_flush = 1'b0;
        w_push  = 1'b0;
        if (r_state != IDLE && !enable) begin
            w_next  = IDLE;
            w_flush = 1'b1;
        end else begin
            case (r_state)
                IDLE:    if (enable)        w_next = WAKE;
                WAKE:    if (w_wake_done)   w_next = SETTLE;
                SETTLE:  if (w_settle_done) w_next = STREAM;
                STREAM:  w_push = sample_valid;
                default: w_next = IDLE;
            endcase
        end
    end

    // Counters restart on every state change, so each phase begins from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wake_cnt   <= '0;
            r_settle_cnt <= '0;
        end else if (w_next != r_state) begin
            r_wake_cnt   <= '0;
            r_settle_cnt <= '0;
        end else if (r_state == WAKE) begin
            r_wake_cnt   <= r_wake_cnt + 1'b1;
        end else if (r_state == SETTLE && sample_valid) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_overflow <= 1'b0;
        else if (r_state == IDLE && enable)
            r_overflow <= 1'b0;
        else if (w_push && w_full && !w_pop)
            r_overflow <= 1'b1;
    end

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_wr_dat   (sample_t'(sample_in)),
        .o_head_dat (w_head),
        .o_level    (w_level),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

`ifdef AUDIO_STREAM_PEAK_EN
    logic [15:0] r_peak;
    logic [15:0] w_abs;

    assign w_abs = sat_abs(sample_t'(sample_in));

    // Peak restarts with each new stream and tracks only samples actually stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_peak <= '0;
        else if (r_state == SETTLE && w_next == STREAM)
            r_peak <= '0;
        else if (w_accept && w_abs > r_peak)
            r_peak <= w_abs;
    end

    assign peak_out = r_peak;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

    assign sample_out = w_head;
    assign data_ready = (r_state == STREAM) && !w_empty;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;
    assign state_out  = r_state;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Bench for audio_stream_ctrl: random and directed stimulus, queue-based reference model and pop scoreboard.
module tb_audio_stream_ctrl;

    localparam int WK = 20;
    localparam int ST = 4;
    localparam int DP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        rd_pulse;
    logic [15:0] sample_out;
    logic        data_ready;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [1:0]  state_out;
`ifdef AUDIO_STREAM_PEAK_EN
    logic [15:0] peak_out;
`endif

    always #5 clk = ~clk;

    audio_stream_ctrl #(
        .WAKE_CYCLES    (WK),
        .SETTLE_SAMPLES (ST),
        .DEPTH          (DP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .rd_pulse     (rd_pulse),
        .sample_out   (sample_out),
        .data_ready   (data_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
`ifdef AUDIO_STREAM_PEAK_EN
        .peak_out     (peak_out),
`endif
        .state_out    (state_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 32767) ? 32767 : a;
    endfunction

    // Reference model: phase number, cycles/strobes spent in it, and the FIFO as a queue.
    int m_state = 0;
    int m_wake  = 0;
    int m_disc  = 0;
    int m_peak  = 0;
    int m_ovf   = 0;
    int sbq[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_wake = 0; m_disc = 0; m_peak = 0; m_ovf = 0;
            sbq.delete();
        end else if (m_state == 0) begin
            if (enable) begin
                m_state = 1; m_wake = 0; m_ovf = 0;
            end
        end else if (!enable) begin
            m_state = 0;
            sbq.delete();
        end else if (m_state == 1) begin
            m_wake++;
            if (m_wake == WK) begin
                m_state = 2; m_disc = 0;
            end
        end else if (m_state == 2) begin
            if (sample_valid) begin
                m_disc++;
                if (m_disc == ST) begin
                    m_state = 3; m_peak = 0;
                end
            end
        end else if (sample_valid) begin
            if (sbq.size() < DP) begin
                sbq.push_back(int'($signed(sample_in)));
                if (mag(int'($signed(sample_in))) > m_peak)
                    m_peak = mag(int'($signed(sample_in)));
            end else begin
                m_ovf = 1;
            end
        end
    end

    // Monitor: compare outputs mid-cycle; on a visible pop handshake, retire the queue head.
    int wake_run   = 0;
    int prev_state = 0;

    always @(negedge clk) begin
        check("state", state_out, m_state);
        check("level", fifo_level, sbq.size());
        check("overflow", overflow, m_ovf);
        check("ready", data_ready, (m_state == 3 && sbq.size() > 0) ? 1 : 0);
        check("head", $signed(sample_out), (sbq.size() > 0) ? sbq[0] : 0);
`ifdef AUDIO_STREAM_PEAK_EN
        check("peak", peak_out, m_peak);
`endif
        if (state_out == 2'd1) begin
            wake_run++;
        end else begin
            if (prev_state == 1 && state_out == 2'd2)
                check("wake_len", wake_run, WK);
            wake_run = 0;
        end
        prev_state = state_out;
        if (rd_pulse && data_ready) begin
            check("pop_avail", (sbq.size() > 0) ? 1 : 0, 1);
            if (sbq.size() > 0) begin
                check("pop_data", $signed(sample_out), sbq[0]);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit v, input int d, input bit r);
        sample_valid = v;
        sample_in    = 16'(d);
        rd_pulse     = r;
        sync();
        sample_valid = 1'b0;
        rd_pulse     = 1'b0;
    endtask

    task automatic go_state(input int s, input int budget);
        int k = 0;
        while (state_out != 2'(s) && k < budget) begin
            cyc(state_out == 2'd2, int'($urandom_range(0, 65535)), 1'b0);
            k++;
        end
        check("reach_state", state_out, s);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; rd_pulse = 1'b0; sample_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state_out, 0);
        check("rst_level", fifo_level, 0);
        check("rst_out", sample_out, 0);
        reset_n = 1'b1;

        // Startup: strobes every 8 cycles once SETTLE is reached; one pop attempt per slot.
        enable = 1'b1;
        go_state(2, 40);
        for (int i = 1; i <= 10; i++) begin
            int used;
            used = 0;
            cyc(1'b1, i, 1'b0);
            if (i == 5) begin
                @(negedge clk);
                check("first_out", sample_out, 5);
                check("first_ready", data_ready, 1);
                sync();
                used = 1;
            end
            for (int j = used; j < 7; j++)
                cyc(1'b0, 0, j == 3);
        end

        // Full FIFO with a simultaneous push and pop.
        for (int k = 0; k < 4; k++) cyc(1'b1, 'h201 + k, 1'b0);
        cyc(1'b1, 'h7FFF, 1'b1);
        @(negedge clk);
        check("full_pp_level", fifo_level, 4);
        check("full_pp_ovf", overflow, 0);
        sync();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                @(negedge clk);
                check("last_pop", sample_out, 'h7FFF);
                sync();
            end
            cyc(1'b0, 0, 1'b1);
            cyc(1'b0, 0, 1'b0);
        end

        // Overflow: five pushes into a four-deep FIFO.
        for (int k = 1; k <= 5; k++) cyc(1'b1, 'h100 + k, 1'b0);
        @(negedge clk);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        sync();
        for (int k = 0; k < 4; k++) cyc(1'b0, 0, 1'b1);

        // Stop/flush with three entries queued, then re-enable.
        for (int k = 1; k <= 3; k++) cyc(1'b1, 'h300 + k, 1'b0);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stop_state", state_out, 0);
        check("stop_level", fifo_level, 0);
        check("stop_ready", data_ready, 0);
        check("stop_out", sample_out, 0);
        check("stop_ovf_kept", overflow, 1);
        sync();
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reen_ovf", overflow, 0);
        sync();
        go_state(3, 200);

        // Reset in the middle of streaming.
        cyc(1'b1, 'h501, 1'b0);
        cyc(1'b1, 'h502, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", state_out, 0);
        check("arst_level", fifo_level, 0);
        check("arst_ready", data_ready, 0);
        check("arst_out", sample_out, 0);
        check("arst_ovf", overflow, 0);
`ifdef AUDIO_STREAM_PEAK_EN
        check("arst_peak", peak_out, 0);
`endif
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_state", state_out, 0);
        sync();
        enable = 1'b1;
        go_state(3, 200);

`ifdef AUDIO_STREAM_PEAK_EN
        begin
            int pv[4];
            int pe[4];
            pv = '{-5, 300, -32768, 12};
            pe = '{5, 300, 32767, 32767};
            check("peak_clear", peak_out, 0);
            for (int k = 0; k < 4; k++) begin
                cyc(1'b1, pv[k], 1'b0);
                @(negedge clk);
                check("peak_seq", peak_out, pe[k]);
                sync();
                cyc(1'b0, 0, 1'b1);
            end
        end
`endif

        // Random traffic in STREAM.
        for (int n = 0; n < 400; n++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            cyc($urandom_range(0, 2) == 0, d, $urandom_range(0, 2) == 0);
        end

        idle_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic idle_end();
        repeat (2) cyc(1'b0, 0, 1'b0);
    endtask

endmodule
